// File: rtl/text_pkg.sv
// Shared types and constants for the text line writer.
package text_pkg;

  localparam int TEXT_LEN = 256;
  localparam int CHAR_W   = 8;
  localparam int CURSOR_W = $clog2(TEXT_LEN + 1);
  localparam int CLR_W    = $clog2(TEXT_LEN);

  typedef logic [CHAR_W-1:0] char_t;

  localparam char_t CHAR_SPACE = 8'h20;
  localparam char_t CHAR_BS    = 8'h08;
  localparam char_t CHAR_LF    = 8'h0A;
  localparam char_t CHAR_FF    = 8'h0C;

  // Cursor value meaning "line full"; writes beyond it are dropped.
  localparam logic [CURSOR_W-1:0] CURSOR_MAX = CURSOR_W'(TEXT_LEN);
  // Last cell index the clear sweep writes before returning to idle.
  localparam logic [CLR_W-1:0]    CLR_LAST   = CLR_W'(TEXT_LEN - 1);

  typedef enum logic {TW_IDLE, TW_CLEAR} tw_state_t;

endpackage

// File: rtl/text_line_writer_if.sv
// Character write handshake between the CPU side and the line writer.
interface text_line_writer_if;

  logic            char_valid;
  text_pkg::char_t char_data;
  logic            char_ready;

  modport master (output char_valid, output char_data, input char_ready);
  modport slave  (input char_valid, input char_data, output char_ready);

endinterface

// File: rtl/text_line_writer.sv
// Line buffer for the text pixel stage: cursor-driven character writes,
// backspace / newline / form-feed handling, and a frame-synchronous shadow
// copy so the pixel stage never sees a half-edited or half-cleared line.
module text_line_writer
  import text_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  text_line_writer_if.slave    cpu,
  input  logic                 clear_req,
  input  logic                 frame_start,
  output char_t                text [TEXT_LEN],
  output logic [CURSOR_W-1:0]  cursor,
  output logic                 busy
);

  tw_state_t             state_q, state_d;
  logic [CLR_W-1:0]      clr_idx_q, clr_idx_d;
  logic [CURSOR_W-1:0]   cursor_q, cursor_d;
  logic                  copy_pend_q, copy_pend_d;
  char_t                 work_q [TEXT_LEN];
  char_t                 work_d [TEXT_LEN];
  char_t                 text_q [TEXT_LEN];
  char_t                 text_d [TEXT_LEN];
  logic                  xfer_s;
  logic [CLR_W-1:0]      bs_idx_s;
  logic [CLR_W-1:0]      wr_idx_s;

  // Ready only in idle, never against a pending clear, and never during reset.
  assign cpu.char_ready = rst_n && (state_q == TW_IDLE) && !clear_req;
  assign xfer_s         = cpu.char_valid && cpu.char_ready;

  // Cell indices for backspace (cursor-1) and normal writes (cursor).
  assign bs_idx_s = cursor_q[CLR_W-1:0] - CLR_W'(1);
  assign wr_idx_s = cursor_q[CLR_W-1:0];

  assign text   = text_q;
  assign cursor = cursor_q;
  assign busy   = (state_q == TW_CLEAR);

  // Next-state, buffer edits, clear sweep and shadow-copy control.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    cursor_d    = cursor_q;
    copy_pend_d = copy_pend_q;
    work_d      = work_q;
    text_d      = text_q;

    case (state_q)
      TW_IDLE: begin
        // Copy uses the pre-edit line; a same-edge write lands next frame.
        if (frame_start || copy_pend_q) begin
          text_d      = work_q;
          copy_pend_d = 1'b0;
        end else begin
          copy_pend_d = copy_pend_q;
        end

        if (clear_req) begin
          state_d   = TW_CLEAR;
          clr_idx_d = '0;
        end else if (xfer_s) begin
          case (cpu.char_data)
            CHAR_BS: begin
              if (cursor_q != '0) begin
                cursor_d         = cursor_q - CURSOR_W'(1);
                work_d[bs_idx_s] = CHAR_SPACE;
              end else begin
                cursor_d = cursor_q;
              end
            end
            CHAR_LF, CHAR_FF: begin
              state_d   = TW_CLEAR;
              clr_idx_d = '0;
            end
            default: begin
              if (cursor_q < CURSOR_MAX) begin
                work_d[wr_idx_s] = cpu.char_data;
                cursor_d         = cursor_q + CURSOR_W'(1);
              end else begin
                cursor_d = cursor_q;
              end
            end
          endcase
        end else begin
          state_d = TW_IDLE;
        end
      end

      TW_CLEAR: begin
        work_d[clr_idx_q] = CHAR_SPACE;
        // Frame boundaries seen mid-sweep collapse into one deferred copy.
        if (frame_start) begin
          copy_pend_d = 1'b1;
        end else begin
          copy_pend_d = copy_pend_q;
        end
        if (clr_idx_q == CLR_LAST) begin
          state_d   = TW_IDLE;
          cursor_d  = '0;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + CLR_W'(1);
        end
      end

      default: begin
        state_d   = TW_IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // State, cursor and both line buffers; reset blanks everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TW_IDLE;
      clr_idx_q   <= '0;
      cursor_q    <= '0;
      copy_pend_q <= 1'b0;
      work_q      <= '{default: CHAR_SPACE};
      text_q      <= '{default: CHAR_SPACE};
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      cursor_q    <= cursor_d;
      copy_pend_q <= copy_pend_d;
      work_q      <= work_d;
      text_q      <= text_d;
    end
  end

endmodule
